// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 self-test: traffic generator state encoding and
// the data pattern, so the read checker can use the identical word definition.
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        WAIT_FOR_INIT = 3'd0,
        WRITE         = 3'd1,
        READ          = 3'd2,
        DRAIN         = 3'd3,
        DONE          = 3'd4,
        ERROR         = 3'd5
    } state_e;

    localparam logic [63:0] PATTERN_BASE = 64'hdeadfadebabebeef;

    // Test word for a given index; idx is zero-extended by the caller.
    function automatic logic [63:0] pattern_word(input logic [63:0] idx, input logic [63:0] base);
        return base ^ idx;
    endfunction

endpackage

// File: rtl/ddr3_test_outstanding_ctr.sv
// Up/down counter of reads accepted but not yet returned, with limit compare on
// the next value and an underflow flag for returns that have no matching read.
module ddr3_test_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 32,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count_nxt,
    output logic          below_limit_nxt,
    output logic          underflow
);

    logic [CW-1:0] count_r;

    // Next count; a return with nothing in flight is flagged and the count is held.
    always_comb begin
        count_nxt = count_r;
        underflow = 1'b0;
        if (en && inc && !dec) begin
            count_nxt = count_r + CW'(1'b1);
        end else if (en && dec && !inc) begin
            if (count_r == {CW{1'b0}}) begin
                underflow = 1'b1;
            end else begin
                count_nxt = count_r - CW'(1'b1);
            end
        end else begin
            count_nxt = count_r;
        end
        below_limit_nxt = (count_nxt < CW'(MAX_OUTSTANDING));
    end

    // Outstanding-read count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_nxt;
        end
    end

endmodule

// File: rtl/ddr3_test_traffic_gen.sv
// DDR3 self-test stimulus: writes the pattern to every test word, then reads all
// words back in order with a bounded number of reads in flight.
module ddr3_test_traffic_gen #(
    parameter int          COUNT_WIDTH     = 25,
    parameter int          ADDR_WIDTH      = 25,
    parameter logic [63:0] PATTERN_BASE    = ddr3_test_pkg::PATTERN_BASE,
    parameter int          MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ddr3_init_done,
    input  logic                  ddr3_cal_success,
    input  logic                  ddr3_cal_fail,
    input  logic                  avl_ready,
    input  logic                  avl_rdata_valid,
    output logic                  avl_burstbegin,
    output logic [ADDR_WIDTH-1:0] avl_addr,
    output logic [63:0]           avl_wdata,
    output logic [7:0]            avl_be,
    output logic [2:0]            avl_size,
    output logic                  avl_read_req,
    output logic                  avl_write_req,
    output logic                  writes_done,
    output logic                  reads_done,
    output logic                  error
);

    import ddr3_test_pkg::*;

    localparam int                     CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [COUNT_WIDTH-1:0] idx_r;
    logic [COUNT_WIDTH-1:0] idx_nxt_s;
    logic                   wr_req_nxt_s;
    logic                   rd_req_nxt_s;
    logic                   writes_done_nxt_s;
    logic                   reads_done_nxt_s;
    logic                   error_nxt_s;
    logic                   wr_accept_s;
    logic                   rd_accept_s;
    logic                   ctr_en_s;
    logic [CW-1:0]          out_cnt_nxt_s;
    logic                   below_limit_s;
    logic                   underflow_s;

    assign wr_accept_s = avl_write_req & avl_ready;
    assign rd_accept_s = avl_read_req & avl_ready;
    assign ctr_en_s    = (state_r == READ) || (state_r == DRAIN);

    ddr3_test_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (CW)
    ) u_outstanding_ctr (
        .clk             (clk),
        .reset_n         (reset_n),
        .en              (ctr_en_s),
        .inc             (rd_accept_s),
        .dec             (avl_rdata_valid),
        .count_nxt       (out_cnt_nxt_s),
        .below_limit_nxt (below_limit_s),
        .underflow       (underflow_s)
    );

    // Next state, index and request levels; requests only move on acceptance.
    always_comb begin
        state_nxt_s       = state_r;
        idx_nxt_s         = idx_r;
        wr_req_nxt_s      = 1'b0;
        rd_req_nxt_s      = 1'b0;
        writes_done_nxt_s = writes_done;
        reads_done_nxt_s  = reads_done;
        error_nxt_s       = error;
        case (state_r)
            WAIT_FOR_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    state_nxt_s  = WRITE;
                    wr_req_nxt_s = 1'b1;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    state_nxt_s = ERROR;
                    error_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT_FOR_INIT;
                end
            end
            WRITE: begin
                wr_req_nxt_s = 1'b1;
                if (wr_accept_s && (idx_r == LAST_IDX)) begin
                    state_nxt_s       = READ;
                    idx_nxt_s         = {COUNT_WIDTH{1'b0}};
                    writes_done_nxt_s = 1'b1;
                    wr_req_nxt_s      = 1'b0;
                    rd_req_nxt_s      = below_limit_s;
                end else if (wr_accept_s) begin
                    idx_nxt_s = idx_r + COUNT_WIDTH'(1'b1);
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            READ: begin
                if (underflow_s) begin
                    state_nxt_s = ERROR;
                    error_nxt_s = 1'b1;
                end else if (rd_accept_s && (idx_r == LAST_IDX)) begin
                    state_nxt_s = DRAIN;
                end else if (rd_accept_s) begin
                    idx_nxt_s    = idx_r + COUNT_WIDTH'(1'b1);
                    rd_req_nxt_s = below_limit_s;
                end else begin
                    rd_req_nxt_s = below_limit_s;
                end
            end
            DRAIN: begin
                if (underflow_s) begin
                    state_nxt_s = ERROR;
                    error_nxt_s = 1'b1;
                end else if (out_cnt_nxt_s == {CW{1'b0}}) begin
                    state_nxt_s      = DONE;
                    reads_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                state_nxt_s = DONE;
            end
            ERROR: begin
                error_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ERROR;
                error_nxt_s = 1'b1;
            end
        endcase
    end

    // State and registered Avalon outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= WAIT_FOR_INIT;
            idx_r          <= {COUNT_WIDTH{1'b0}};
            avl_write_req  <= 1'b0;
            avl_read_req   <= 1'b0;
            avl_burstbegin <= 1'b0;
            avl_addr       <= {ADDR_WIDTH{1'b0}};
            avl_wdata      <= 64'h0;
            avl_be         <= 8'hff;
            avl_size       <= 3'd1;
            writes_done    <= 1'b0;
            reads_done     <= 1'b0;
            error          <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            idx_r          <= idx_nxt_s;
            avl_write_req  <= wr_req_nxt_s;
            avl_read_req   <= rd_req_nxt_s;
            avl_burstbegin <= wr_req_nxt_s | rd_req_nxt_s;
            avl_addr       <= ADDR_WIDTH'(idx_nxt_s);
            avl_wdata      <= pattern_word(64'(idx_nxt_s), PATTERN_BASE);
            avl_be         <= 8'hff;
            avl_size       <= 3'd1;
            writes_done    <= writes_done_nxt_s;
            reads_done     <= reads_done_nxt_s;
            error          <= error_nxt_s;
        end
    end

endmodule

// File: tb/tb_ddr3_test_traffic_gen.sv
// Directed bench for ddr3_test_traffic_gen with 9 test words and 2 reads in flight.
module tb_ddr3_test_traffic_gen;

    localparam logic [63:0] BASE = 64'hdeadfadebabebeef;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ddr3_init_done, ddr3_cal_success, ddr3_cal_fail;
    logic        avl_ready, avl_rdata_valid;
    logic        avl_burstbegin;
    logic [5:0]  avl_addr;
    logic [63:0] avl_wdata;
    logic [7:0]  avl_be;
    logic [2:0]  avl_size;
    logic        avl_read_req, avl_write_req;
    logic        writes_done, reads_done, error;

    int err_cnt = 0;
    int chk_cnt = 0;

    ddr3_test_traffic_gen #(
        .COUNT_WIDTH     (4),
        .ADDR_WIDTH      (6),
        .PATTERN_BASE    (BASE),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ddr3_init_done   (ddr3_init_done),
        .ddr3_cal_success (ddr3_cal_success),
        .ddr3_cal_fail    (ddr3_cal_fail),
        .avl_ready        (avl_ready),
        .avl_rdata_valid  (avl_rdata_valid),
        .avl_burstbegin   (avl_burstbegin),
        .avl_addr         (avl_addr),
        .avl_wdata        (avl_wdata),
        .avl_be           (avl_be),
        .avl_size         (avl_size),
        .avl_read_req     (avl_read_req),
        .avl_write_req    (avl_write_req),
        .writes_done      (writes_done),
        .reads_done       (reads_done),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       pre_req;
        logic [5:0] pre_addr;
        logic [63:0] pre_data;
        logic [7:0] lfsr;
        int         exp_idx;
        int         cyc;

        reset_n = 1'b0; ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
        avl_ready = 1'b1; avl_rdata_valid = 1'b0;
        repeat (2) tick;
        check_eq("rst_wr_req", avl_write_req, 1'b0);
        check_eq("rst_rd_req", avl_read_req, 1'b0);
        check_eq("rst_bb", avl_burstbegin, 1'b0);
        check_eq("rst_addr", avl_addr, 6'd0);
        check_eq("rst_wdata", avl_wdata, 64'h0);
        check_eq("rst_be", avl_be, 8'hff);
        check_eq("rst_size", avl_size, 3'd1);
        check_eq("rst_flags", {writes_done, reads_done, error}, 3'b000);
        reset_n = 1'b1;
        repeat (4) tick;
        check_eq("idle_no_req", avl_write_req | avl_read_req, 1'b0);

        // Run 1: full write pass, throttled reads, delayed drain.
        ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
        tick;
        for (int i = 0; i < 9; i++) begin
            check_eq("wr_req", avl_write_req, 1'b1);
            check_eq("wr_bb", avl_burstbegin, 1'b1);
            check_eq("wr_rd_req", avl_read_req, 1'b0);
            check_eq("wr_addr", avl_addr, 64'(i));
            check_eq("wr_data", avl_wdata, BASE ^ 64'(i));
            check_eq("wr_done_early", writes_done, 1'b0);
            if (i == 8) check_eq("wr_data_last", avl_wdata, 64'hdeadfadebabebee7);
            tick;
        end
        check_eq("writes_done", writes_done, 1'b1);
        check_eq("wr_req_off", avl_write_req, 1'b0);
        check_eq("rd_req_on", avl_read_req, 1'b1);
        check_eq("rd_addr0", avl_addr, 6'd0);
        tick;
        check_eq("rd_req_1", avl_read_req, 1'b1);
        check_eq("rd_addr1", avl_addr, 6'd1);
        tick;
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_limit_hold", avl_read_req, 1'b0);
            tick;
        end
        avl_rdata_valid = 1'b1;
        tick;
        avl_rdata_valid = 1'b0;
        check_eq("rd_slot_reopen", avl_read_req, 1'b1);
        check_eq("rd_addr2", avl_addr, 6'd2);
        tick;
        check_eq("rd_limit_again", avl_read_req, 1'b0);
        avl_rdata_valid = 1'b1;
        tick;
        check_eq("rd_addr3", avl_addr, 6'd3);
        tick;
        avl_rdata_valid = 1'b0;
        check_eq("same_cycle_req", avl_read_req, 1'b1);
        check_eq("same_cycle_addr", avl_addr, 6'd4);
        tick;
        check_eq("same_cycle_limit", avl_read_req, 1'b0);
        for (int a = 5; a <= 8; a++) begin
            avl_rdata_valid = 1'b1;
            tick;
            avl_rdata_valid = 1'b0;
            check_eq("rd_req_n", avl_read_req, 1'b1);
            check_eq("rd_addr_n", avl_addr, 64'(a));
            tick;
        end
        check_eq("drain_no_req", avl_read_req, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check_eq("drain_wait", reads_done, 1'b0);
            tick;
        end
        avl_rdata_valid = 1'b1;
        tick;
        check_eq("drain_one_left", reads_done, 1'b0);
        tick;
        avl_rdata_valid = 1'b0;
        check_eq("reads_done", reads_done, 1'b1);
        avl_rdata_valid = 1'b1;
        tick;
        avl_rdata_valid = 1'b0;
        repeat (2) tick;
        check_eq("done_flags", {writes_done, reads_done, error}, 3'b110);
        check_eq("done_no_req", avl_write_req | avl_read_req, 1'b0);

        // Run 2: reset mid-write at idx 5, then random ready back-pressure.
        reset_n = 1'b0;
        #1;
        check_eq("rst2_flags", {writes_done, reads_done, error}, 3'b000);
        tick;
        reset_n = 1'b1;
        tick;
        repeat (5) tick;
        check_eq("mid_wr_addr", avl_addr, 6'd5);
        check_eq("mid_wr_req", avl_write_req, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_req", avl_write_req, 1'b0);
        check_eq("async_rst_addr", avl_addr, 6'd0);
        check_eq("async_rst_data", avl_wdata, 64'h0);
        tick;
        reset_n = 1'b1;
        exp_idx = 0;
        cyc = 0;
        lfsr = 8'ha5;
        while (exp_idx < 9 && cyc < 300) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            avl_ready = lfsr[0];
            pre_req = avl_write_req;
            pre_addr = avl_addr;
            pre_data = avl_wdata;
            check_eq("bp_no_rd", avl_read_req, 1'b0);
            tick;
            if (pre_req && avl_ready) begin
                check_eq("bp_addr", pre_addr, 64'(exp_idx));
                check_eq("bp_data", pre_data, BASE ^ 64'(exp_idx));
                exp_idx++;
            end else if (pre_req) begin
                check_eq("bp_hold_req", avl_write_req, 1'b1);
                check_eq("bp_hold_addr", avl_addr, pre_addr);
                check_eq("bp_hold_data", avl_wdata, pre_data);
            end
            cyc++;
        end
        check_eq("bp_all_writes", 64'(exp_idx), 64'd9);
        check_eq("bp_writes_done", writes_done, 1'b1);
        check_eq("bp_rd_start", avl_read_req, 1'b1);
        check_eq("bp_rd_addr0", avl_addr, 6'd0);

        // Spurious return with nothing in flight.
        avl_ready = 1'b0;
        avl_rdata_valid = 1'b1;
        tick;
        avl_rdata_valid = 1'b0;
        check_eq("underflow_err", error, 1'b1);
        check_eq("underflow_no_req", avl_read_req, 1'b0);
        repeat (3) tick;
        check_eq("err_sticky", error, 1'b1);
        check_eq("err_no_req", avl_write_req | avl_read_req | avl_burstbegin, 1'b0);

        // Run 3: calibration failure.
        reset_n = 1'b0;
        ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; avl_ready = 1'b1;
        tick;
        check_eq("rst3_err", error, 1'b0);
        reset_n = 1'b1;
        tick;
        ddr3_init_done = 1'b1; ddr3_cal_fail = 1'b1;
        check_eq("pre_calfail_err", error, 1'b0);
        tick;
        check_eq("calfail_err", error, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("calfail_no_req", avl_write_req | avl_read_req, 1'b0);
            tick;
        end

        // Run 4: success wins over fail.
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        ddr3_cal_success = 1'b1;
        tick;
        check_eq("both_wr_req", avl_write_req, 1'b1);
        check_eq("both_no_err", error, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
